// File: rtl/arith_cmd_sequencer.sv
// arith_cmd_sequencer
// Initiator-side front end for the arithmetic unit. Takes one operation at a
// time on a valid/ready command port, drives the unit's operand/function/enable
// registers, captures the unit's result when Arith_Flag rises and returns it on
// a valid/ready response port. Divide-by-zero is refused without issuing, and a
// unit that never raises Arith_Flag is timed out with an error response.
module arith_cmd_sequencer #(
    parameter int Width   = 16,
    parameter int TIMEOUT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST,

    // command port
    input  logic             Cmd_Valid,
    output logic             Cmd_Ready,
    input  logic [Width-1:0] Cmd_A,
    input  logic [Width-1:0] Cmd_B,
    input  logic [1:0]       Cmd_Func,

    // arithmetic unit interface
    output logic [Width-1:0] A,
    output logic [Width-1:0] B,
    output logic [1:0]       ALU_FUNC,
    output logic             Arith_Enable,
    input  logic [Width-1:0] Arith_OUT,
    input  logic             Carry_OUT,
    input  logic             Arith_Flag,

    // response port
    output logic             Rsp_Valid,
    input  logic             Rsp_Ready,
    output logic [Width-1:0] Rsp_Data,
    output logic             Rsp_Carry,
    output logic             Rsp_Err,

    // completed-response counter, wraps
    output logic [CNT_W-1:0] Op_Count
);

    // Timer only has to reach TIMEOUT-1; TIMEOUT is at least 2.
    localparam int               TMR_W    = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [1:0]       FUNC_DIV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [TMR_W-1:0] timer_q;

    // One-cycle decode strobes shared by the state and datapath registers.
    logic accept;     // command handshake this cycle
    logic div_zero;   // accepted command is a divide by zero
    logic flag_hit;   // unit result arrives while waiting
    logic timed_out;  // unit stayed silent for TIMEOUT wait cycles
    logic rsp_done;   // response handshake this cycle

    // Ready is a pure decode of the state register, never of the inputs.
    assign Cmd_Ready = (state_q == S_IDLE);

    // State register.
    // NOTE: RST is sampled on the clock edge (synchronous reset), and every
    // sequential assignment is non-blocking so all registers update together.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and handshake/event strobes.
    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        div_zero  = 1'b0;
        flag_hit  = 1'b0;
        timed_out = 1'b0;
        rsp_done  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (Cmd_Valid) begin
                    accept = 1'b1;
                    if (Cmd_Func == FUNC_DIV && Cmd_B == '0) begin
                        div_zero = 1'b1;
                        state_d  = S_RESP;
                    end else begin
                        state_d  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A result arriving on the last allowed cycle still wins.
                if (Arith_Flag) begin
                    flag_hit = 1'b1;
                    state_d  = S_RESP;
                end else if (timer_q == TMR_LAST) begin
                    timed_out = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (Rsp_Ready) begin
                    rsp_done = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Unit-side registers: operands latch only on accept, so they stay frozen
    // for the whole wait; enable covers exactly the wait state.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            A            <= '0;
            B            <= '0;
            ALU_FUNC     <= 2'b00;
            Arith_Enable <= 1'b0;
            timer_q      <= '0;
        end else begin
            if (accept) begin
                A        <= Cmd_A;
                B        <= Cmd_B;
                ALU_FUNC <= Cmd_Func;
                if (!div_zero) begin
                    Arith_Enable <= 1'b1;
                    timer_q      <= '0;
                end
            end

            if (state_q == S_WAIT) begin
                if (flag_hit || timed_out) begin
                    Arith_Enable <= 1'b0;
                end else begin
                    timer_q <= timer_q + TMR_W'(1);
                end
            end
        end
    end

    // Response registers and completed-operation counter. Payload is only
    // written when a response is formed, so it holds while Rsp_Ready is low.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            Rsp_Valid <= 1'b0;
            Rsp_Data  <= '0;
            Rsp_Carry <= 1'b0;
            Rsp_Err   <= 1'b0;
            Op_Count  <= '0;
        end else begin
            if (div_zero || timed_out) begin
                Rsp_Valid <= 1'b1;
                Rsp_Data  <= '0;
                Rsp_Carry <= 1'b0;
                Rsp_Err   <= 1'b1;
            end else if (flag_hit) begin
                Rsp_Valid <= 1'b1;
                Rsp_Data  <= Arith_OUT;
                Rsp_Carry <= Carry_OUT;
                Rsp_Err   <= 1'b0;
            end

            if (rsp_done) begin
                Rsp_Valid <= 1'b0;
                Op_Count  <= Op_Count + CNT_W'(1);
            end
        end
    end

endmodule
